// File: rtl/min_scan_pkg.sv
// Shared types and constants for the min-scan bus initiator.
// Build option: define MIN_SCAN_UNSIGNED_EN for an unsigned compare and an
// all-ones empty-array value sentinel.
package min_scan_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned VAL_OFFSET = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WR_IDX = 3'd2,
        WR_VAL = 3'd3,
        DONE   = 3'd4
    } state_e;

    // Written when the array is empty.
    localparam logic [DATA_W-1:0] EMPTY_IDX = 32'hFFFF_FFFF;
`ifdef MIN_SCAN_UNSIGNED_EN
    localparam logic [DATA_W-1:0] EMPTY_VAL = 32'hFFFF_FFFF;
`else
    localparam logic [DATA_W-1:0] EMPTY_VAL = 32'h7FFF_FFFF;
`endif

    // Byte address of element idx; wraps modulo 2^32.
    function automatic logic [ADDR_W-1:0] elem_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [ADDR_W-1:0] idx);
        return ADDR_W'(base + ADDR_W'(idx * ADDR_W'(WORD_BYTES)));
    endfunction

endpackage

// File: rtl/min_scan_master_if.sv
// Data-memory bus between the min-scan initiator and the memory.
interface min_scan_master_if;
    import min_scan_pkg::*;

    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mread;
    logic              mwrite;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output adr,
        output mem_wdata,
        output mread,
        output mwrite,
        input  mem_rdata
    );

    modport slave (
        input  adr,
        input  mem_wdata,
        input  mread,
        input  mwrite,
        output mem_rdata
    );

endinterface

// File: rtl/min_scan_cmp.sv
// Running-minimum update decision. Build option: MIN_SCAN_UNSIGNED_EN.
module min_scan_cmp
    import min_scan_pkg::*;
(
    input  logic [DATA_W-1:0] cand_i,
    input  logic [DATA_W-1:0] min_i,
    input  logic              first_i,
    output logic              take_o
);

    logic less;

    // Strict less-than so the first occurrence of a tie keeps the index.
    always_comb begin
`ifdef MIN_SCAN_UNSIGNED_EN
        less   = (cand_i < min_i);
`else
        less   = ($signed(cand_i) < $signed(min_i));
`endif
        take_o = first_i | less;
    end

endmodule

// File: rtl/min_scan_master.sv
// Min-search bus initiator: scans a word array, writes min index and value.
// Build option: MIN_SCAN_UNSIGNED_EN selects unsigned comparison.
module min_scan_master
    import min_scan_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESULT_ADDR = 32'd2000,
    parameter int unsigned       CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [CNT_W-1:0]     count,
    min_scan_master_if.master    bus,
    output logic                 busy,
    output logic                 done
);

    state_e state_q, state_d;

    logic [ADDR_W-1:0] base_q,    base_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [CNT_W-1:0]  i_q,       i_d;
    logic [DATA_W-1:0] min_val_q, min_val_d;
    logic [DATA_W-1:0] min_idx_q, min_idx_d;

    logic [ADDR_W-1:0] adr_q,   adr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mread_q, mread_d;
    logic              mwrite_q, mwrite_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    logic              take;
    logic              first_elem;
    logic              last_elem;

    assign first_elem = (i_q == '0);
    assign last_elem  = (i_q == CNT_W'(cnt_q - CNT_W'(1)));

    min_scan_cmp u_cmp (
        .cand_i  (bus.mem_rdata),
        .min_i   (min_val_q),
        .first_i (first_elem),
        .take_o  (take)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (count == '0) ? WR_IDX : READ;
            READ:    if (last_elem) state_d = WR_IDX;
            WR_IDX:  state_d = WR_VAL;
            WR_VAL:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Scan datapath: latched request, element index and running minimum.
    always_comb begin
        base_d    = base_q;
        cnt_d     = cnt_q;
        i_d       = i_q;
        min_val_d = min_val_q;
        min_idx_d = min_idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d    = base_addr;
                    cnt_d     = count;
                    i_d       = '0;
                    min_val_d = EMPTY_VAL;
                    min_idx_d = EMPTY_IDX;
                end
            end
            READ: begin
                if (take) begin
                    min_val_d = bus.mem_rdata;
                    min_idx_d = DATA_W'(i_q);
                end
                i_d = CNT_W'(i_q + CNT_W'(1));
            end
            default: ;
        endcase
    end

    // Bus outputs for the upcoming state, so strobes leave a register.
    always_comb begin
        adr_d    = '0;
        wdata_d  = '0;
        mread_d  = 1'b0;
        mwrite_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_d)
            READ: begin
                adr_d   = elem_addr(base_d, ADDR_W'(i_d));
                mread_d = 1'b1;
                busy_d  = 1'b1;
            end
            WR_IDX: begin
                adr_d    = RESULT_ADDR;
                wdata_d  = min_idx_d;
                mwrite_d = 1'b1;
                busy_d   = 1'b1;
            end
            WR_VAL: begin
                adr_d    = ADDR_W'(RESULT_ADDR + ADDR_W'(VAL_OFFSET));
                wdata_d  = min_val_d;
                mwrite_d = 1'b1;
                busy_d   = 1'b1;
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q    <= '0;
            cnt_q     <= '0;
            i_q       <= '0;
            min_val_q <= '0;
            min_idx_q <= '0;
            adr_q     <= '0;
            wdata_q   <= '0;
            mread_q   <= 1'b0;
            mwrite_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            base_q    <= base_d;
            cnt_q     <= cnt_d;
            i_q       <= i_d;
            min_val_q <= min_val_d;
            min_idx_q <= min_idx_d;
            adr_q     <= adr_d;
            wdata_q   <= wdata_d;
            mread_q   <= mread_d;
            mwrite_q  <= mwrite_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.adr       = adr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mread     = mread_q;
    assign bus.mwrite    = mwrite_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule
